// File: rtl/space_pkg.sv
// Shared constants, state encoding and debug view for the play-screen units
// (laser, ship, alien).
package space_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [7:0] COLOR_BLACK = 8'h00;
  localparam logic [7:0] COLOR_GREEN = 8'b000_111_00;
  localparam logic [7:0] COLOR_RED   = 8'b111_000_00;
  localparam logic [7:0] COLOR_WHITE = 8'hff;

  localparam int SHIP_W_DEF  = 32;
  localparam int LASER_W_DEF = 2;
  localparam int LASER_H_DEF = 8;
  localparam int ALIEN_W_DEF = 32;
  localparam int ALIEN_H_DEF = 16;

  localparam int COOL_W = 8;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } laser_state_t;

  typedef struct packed {
    laser_state_t      state;
    logic [9:0]        laser_x;
    logic [9:0]        laser_y;
    logic [COOL_W-1:0] cool_cnt;
  } laser_dbg_t;

endpackage

// File: rtl/laser_if.sv
// Pixel/position inputs and drawing/event outputs of the laser unit.
interface laser_if;
  import space_pkg::*;

  logic [9:0] x;
  logic [9:0] y;
  logic       shoot;
  logic [9:0] ship_x;
  logic [9:0] ship_y;
  logic [9:0] alien_x;
  logic [9:0] alien_y;
  logic       alien_alive;
  logic [7:0] laser_color;
  logic       laser_active;
  logic       hit;
  logic       miss;
  laser_dbg_t dbg;

  // Valid/ready semantics do not apply: every signal is sampled each clock.
  // shoot, hit and miss are single-cycle pulses; the rest are levels.
  modport master (
    output x, y, shoot, ship_x, ship_y, alien_x, alien_y, alien_alive,
    input  laser_color, laser_active, hit, miss, dbg
  );

  modport slave (
    input  x, y, shoot, ship_x, ship_y, alien_x, alien_y, alien_alive,
    output laser_color, laser_active, hit, miss, dbg
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle pulse when the scan position first lands on (0, TICK_LINE).
module frame_tick_gen #(
  parameter int TICK_LINE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       tick
);

  logic match;
  logic match_q;

  assign match = (x == 10'd0) && (y == 10'(TICK_LINE));

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match;
  end

  // Edge detect so a position held for several cycles still ticks once.
  assign tick = match && !match_q;

endmodule

// File: rtl/laser_unit.sv
// Player laser: fire from the ship nose, climb once per frame, report hit/miss,
// then hold off new shots for a frame-counted cooldown.
module laser_unit
  import space_pkg::*;
#(
  parameter int         SHIP_W          = SHIP_W_DEF,
  parameter int         LASER_W         = LASER_W_DEF,
  parameter int         LASER_H         = LASER_H_DEF,
  parameter int         ALIEN_W         = ALIEN_W_DEF,
  parameter int         ALIEN_H         = ALIEN_H_DEF,
  parameter int         SPEED           = 4,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter int         TICK_LINE       = 480,
  parameter logic [7:0] LASER_COLOR     = COLOR_GREEN
) (
  input logic   clk,
  input logic   reset,
  laser_if.slave bus
);

  localparam logic [9:0]        NOSE_OFF = 10'(SHIP_W / 2 - LASER_W / 2);
  localparam logic [9:0]        LH10     = 10'(LASER_H);
  localparam logic [9:0]        SPEED10  = 10'(SPEED);
  localparam logic [10:0]       LW11     = 11'(LASER_W);
  localparam logic [10:0]       LH11     = 11'(LASER_H);
  localparam logic [10:0]       AW11     = 11'(ALIEN_W);
  localparam logic [10:0]       AH11     = 11'(ALIEN_H);
  localparam logic [COOL_W-1:0] CD_INIT  = COOL_W'(COOLDOWN_FRAMES);

  laser_state_t      state, state_d;
  logic [9:0]        laser_x, laser_x_d;
  logic [9:0]        laser_y, laser_y_d;
  logic [COOL_W-1:0] cool_cnt, cool_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              tick;
  logic              overlap;
  logic              in_x, in_y;
  logic              active;
  logic [7:0]        color;

  frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .x     (bus.x),
    .y     (bus.y),
    .tick  (tick)
  );

  // Widened to 11 bits so edge+size never wraps near the screen limit.
  assign overlap = bus.alien_alive
                && ({1'b0, laser_x} < {1'b0, bus.alien_x} + AW11)
                && ({1'b0, bus.alien_x} < {1'b0, laser_x} + LW11)
                && ({1'b0, laser_y} < {1'b0, bus.alien_y} + AH11)
                && ({1'b0, bus.alien_y} < {1'b0, laser_y} + LH11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_READY;
      laser_x  <= '0;
      laser_y  <= '0;
      cool_cnt <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state    <= state_d;
      laser_x  <= laser_x_d;
      laser_y  <= laser_y_d;
      cool_cnt <= cool_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  always_comb begin
    state_d   = state;
    laser_x_d = laser_x;
    laser_y_d = laser_y;
    cool_d    = cool_cnt;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    case (state)
      ST_READY: begin
        if (bus.shoot) begin
          state_d   = ST_FLYING;
          laser_x_d = bus.ship_x + NOSE_OFF;
          laser_y_d = (bus.ship_y < LH10) ? 10'd0 : bus.ship_y - LH10;
        end
      end
      ST_FLYING: begin
        // Hit is tested first so it wins over a same-tick exit at the top.
        if (tick) begin
          if (overlap) begin
            hit_d   = 1'b1;
            state_d = ST_COOLDOWN;
            cool_d  = CD_INIT;
          end else if (laser_y < SPEED10) begin
            miss_d  = 1'b1;
            state_d = ST_COOLDOWN;
            cool_d  = CD_INIT;
          end else begin
            laser_y_d = laser_y - SPEED10;
          end
        end
      end
      ST_COOLDOWN: begin
        if (cool_cnt == '0) begin
          state_d = ST_READY;
        end else if (tick) begin
          cool_d = cool_cnt - 1'b1;
          if (cool_cnt == COOL_W'(1)) state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_comb begin
    active = (state == ST_FLYING);
    in_x   = ({1'b0, bus.x} >= {1'b0, laser_x}) && ({1'b0, bus.x} < {1'b0, laser_x} + LW11);
    in_y   = ({1'b0, bus.y} >= {1'b0, laser_y}) && ({1'b0, bus.y} < {1'b0, laser_y} + LH11);
    color  = (active && in_x && in_y) ? LASER_COLOR : 8'h00;
  end

  assign bus.laser_color  = color;
  assign bus.laser_active = active;
  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.dbg          = '{state: state, laser_x: laser_x, laser_y: laser_y, cool_cnt: cool_cnt};

endmodule

// File: tb/tb_laser_unit.sv
// Randomised and directed shots against a flight model; hit/miss pulses are
// scoreboarded by frame-tick index.
module tb_laser_unit;
  import space_pkg::*;

  localparam int SHIP_W  = 32;
  localparam int LASER_W = 2;
  localparam int LASER_H = 8;
  localparam int ALIEN_W = 32;
  localparam int ALIEN_H = 16;
  localparam int SPEED   = 4;
  localparam int COOL_N  = 8;
  localparam logic [7:0] GREEN = 8'h1c;
  localparam int W = 18;

  logic clk;
  logic reset;
  laser_if bus ();

  laser_unit #(
    .SHIP_W(SHIP_W), .LASER_W(LASER_W), .LASER_H(LASER_H),
    .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .SPEED(SPEED),
    .COOLDOWN_FRAMES(COOL_N), .TICK_LINE(480), .LASER_COLOR(GREEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input int xv, input int yv, input bit sh);
    bus.x     = 10'(xv);
    bus.y     = 10'(yv);
    bus.shoot = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    tick_cnt++;
    cyc(0, 480, 0);
    cyc(1, 481, 0);
    cyc(2, 481, 0);
  endtask

  task automatic pix(input string name, input int xv, input int yv, input bit sh, input logic [7:0] expc);
    cyc(xv, yv, sh);
    check(name, bus.laser_color, expc);
  endtask

  // Reference flight: ticks until the shot resolves, and whether it hits.
  function automatic int model_flight(input int lx, input int ly, input int ax, input int ay,
                                      input bit alive, output bit is_hit);
    int p;
    p = ly;
    is_hit = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      if (alive && lx < ax + ALIEN_W && ax < lx + LASER_W && p < ay + ALIEN_H && ay < p + LASER_H) begin
        is_hit = 1'b1;
        return k;
      end
      if (p < SPEED) return k;
      p -= SPEED;
    end
    return -1;
  endfunction

  int cur_lx, cur_ly, cur_k;

  task automatic fire(input int sx, input int sy, input int ax, input int ay,
                      input bit alive, input bit model_alive);
    bit is_hit;
    bus.ship_x      = 10'(sx);
    bus.ship_y      = 10'(sy);
    bus.alien_x     = 10'(ax);
    bus.alien_y     = 10'(ay);
    bus.alien_alive = alive;
    check("ready_before_fire", 32'(bus.dbg.state), 32'(ST_READY));
    cyc(100, 100, 1);
    cur_lx = sx + SHIP_W / 2 - LASER_W / 2;
    cur_ly = (sy < LASER_H) ? 0 : sy - LASER_H;
    check("active_after_fire", bus.laser_active, 1);
    check("laser_x_load", bus.dbg.laser_x, cur_lx);
    check("laser_y_load", bus.dbg.laser_y, cur_ly);
    cur_k = model_flight(cur_lx, cur_ly, ax, ay, model_alive, is_hit);
    exp_q.push_back({16'(tick_cnt + cur_k), is_hit, !is_hit});
  endtask

  // Fly until the laser goes inactive; probe once at frame m, optionally kill the alien.
  task automatic fly(input int m, input int drop_at);
    int f;
    int py;
    f = 0;
    while (bus.laser_active && f < 400) begin
      if (f == m) begin
        py = cur_ly - SPEED * f;
        check("mid_laser_y", bus.dbg.laser_y, py);
        bus.ship_x = 10'($urandom_range(0, 600));
        pix("mid_pix_on", cur_lx, py, 1, GREEN);
        pix("mid_pix_right", cur_lx + LASER_W, py, 0, 8'h00);
      end
      if (f == drop_at) bus.alien_alive = 1'b0;
      frame();
      f++;
    end
    check("flight_ticks", f, cur_k);
    check("inactive_after_flight", bus.laser_active, 0);
  endtask

  task automatic cooldown();
    for (int t = 0; t < COOL_N; t++) begin
      check("cool_state", 32'(bus.dbg.state), 32'(ST_COOLDOWN));
      cyc(100, 100, 1);
      check("cool_shoot_ignored", bus.laser_active, 0);
      repeat (19) cyc(50, 50, 0);
      frame();
    end
    check("ready_after_cool", 32'(bus.dbg.state), 32'(ST_READY));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (!reset && (bus.hit || bus.miss)) begin
      n_tests++;
      act = {16'(tick_cnt), bus.hit, bus.miss};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got tick=%0d hit=%b miss=%b required no pulse",
                 tick_cnt, bus.hit, bus.miss);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL pulse_event: got tick=%0d hit=%b miss=%b required tick=%0d hit=%b miss=%b",
                   act[17:2], act[1], act[0], e[17:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ax, ay, sx, sy, lx, ly, k, m;
    bit alive, dummy;
    bus.x = '0; bus.y = '0; bus.shoot = 1'b0;
    bus.ship_x = 10'd300; bus.ship_y = 10'd440;
    bus.alien_x = 10'd0; bus.alien_y = 10'd0; bus.alien_alive = 1'b0;
    reset = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b0;

    check("rst_state", 32'(bus.dbg.state), 32'(ST_READY));
    check("rst_laser_x", bus.dbg.laser_x, 0);
    check("rst_laser_y", bus.dbg.laser_y, 0);
    check("rst_cool", bus.dbg.cool_cnt, 0);
    repeat (3) frame();
    check("idle_active", bus.laser_active, 0);
    check("idle_hit_miss", {bus.hit, bus.miss}, 0);
    pix("idle_pix_origin", 0, 0, 0, 8'h00);
    pix("idle_pix_mid", 315, 432, 0, 8'h00);

    // Miss path with pixel edges.
    fire(300, 440, 312, 100, 1'b0, 1'b0);
    check("miss_k", cur_k, 109);
    pix("pix_x315", 315, 432, 0, GREEN);
    pix("pix_x316", 316, 432, 0, GREEN);
    pix("pix_x317", 317, 432, 0, 8'h00);
    pix("pix_y439", 315, 439, 0, GREEN);
    pix("pix_y440", 315, 440, 0, 8'h00);
    pix("pix_y431", 315, 431, 0, 8'h00);
    fly(108, -1);
    cooldown();

    // Hit path: laser at 112 after 80 ticks, hit on tick 81.
    fire(300, 440, 312, 100, 1'b1, 1'b1);
    check("hit_k", cur_k, 81);
    fly(80, -1);
    cooldown();

    // Alien dies mid-flight: the shot can only miss.
    bus.ship_x = 10'd300;
    fire(300, 440, 312, 100, 1'b1, 1'b0);
    fly(5, 10);
    cooldown();

    // Clamp at the top: immediate miss.
    fire(300, 4, 312, 300, 1'b1, 1'b1);
    check("clamp_k", cur_k, 1);
    fly(0, -1);
    cooldown();

    // Reset while flying drops the shot without a pulse.
    fire(200, 400, 0, 0, 1'b0, 1'b0);
    repeat (3) frame();
    reset = 1'b1;
    cyc(215, 392 - 12, 0);
    check("rst_fly_active", bus.laser_active, 0);
    check("rst_fly_color", bus.laser_color, 8'h00);
    check("rst_fly_state", 32'(bus.dbg.state), 32'(ST_READY));
    exp_q.delete();
    reset = 1'b0;
    repeat (3) frame();
    check("post_rst_hit_miss", {bus.hit, bus.miss}, 0);

    // Random shots, alien often in the laser column.
    for (int s = 0; s < 14; s++) begin
      ax = $urandom_range(40, 560);
      ay = $urandom_range(0, 300);
      sx = ax - 30 + $urandom_range(0, 50);
      sy = $urandom_range(0, 470);
      alive = ($urandom_range(0, 3) != 0);
      lx = sx + SHIP_W / 2 - LASER_W / 2;
      ly = (sy < LASER_H) ? 0 : sy - LASER_H;
      k = model_flight(lx, ly, ax, ay, alive, dummy);
      m = $urandom_range(0, k - 1);
      fire(sx, sy, ax, ay, alive, alive);
      fly(m, -1);
      cooldown();
    end

    repeat (2) frame();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
